serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A, latched when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B, latched when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in, latched when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress (HA1/HA2 states).
REQ-009 SHALL have port: done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, A+B+cin modulo 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL implement the addition bit-serially, LSB first, through one shared half-adder cell used twice per bit.
REQ-013 SHALL implement FSM states IDLE, HA1, HA2, DONE.
REQ-014 IDLE: start=1 at a clock edge SHALL latch a, b, cin, clear bit index to 0, and enter HA1; start=0 SHALL stay in IDLE.
REQ-015 HA1: the cell SHALL compute a[i], b[i] -> partial sum p, carry c1; p and c1 registered; next state HA2.
REQ-016 HA2: the cell SHALL compute p and running carry -> sum bit i, carry c2; running carry SHALL become c1 OR c2; sum bit i stored in internal shift/result register.
REQ-017 HA2 with bit index < WIDTH-1 SHALL increment the index and return to HA1; at index WIDTH-1 SHALL enter DONE.
REQ-018 On entry to DONE, sum and cout outputs SHALL load the internal result and final carry in the same edge; done=1 for exactly the DONE cycle; next state IDLE.
REQ-019 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E(2*WIDTH) (17th cycle for WIDTH=8); throughput one addition per 2*WIDTH+2 cycles.
REQ-020 sum and cout SHALL hold their last result from DONE until the next DONE; they SHALL NOT change during HA1/HA2.
REQ-021 start while busy or in DONE SHALL be ignored with no effect on latched operands or result.
REQ-022 Operand inputs a, b, cin SHALL be don't-care except at the accepting edge.
REQ-023 busy SHALL be 1 exactly in HA1 and HA2; busy and done SHALL never be 1 simultaneously.
REQ-024 Wrap-around: a carry out of bit WIDTH-1 SHALL appear only on cout; sum SHALL be the low WIDTH bits.

Reset
REQ-025 rst=1 SHALL force, asynchronously, state IDLE, busy=0, done=0, sum=0, cout=0, bit index=0, running carry=0, all operand latches 0.
REQ-026 rst asserted mid-operation SHALL abort the addition; no done pulse SHALL be produced for it; first start after rst deassertion SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (IDLE, HA1, HA2, DONE, 2-bit) and the WIDTH default.
REQ-028 Exactly one sub-module SHALL be instantiated: ha_cell, a combinational half adder (inputs x, y; outputs s = x XOR y, c = x AND y).
REQ-029 Bit index counter width SHALL be ceil(log2(WIDTH)) bits.

Verification
REQ-030 WIDTH=8, a=3, b=5, cin=0, start pulse -> busy high 16 cycles, done in 17th cycle, sum=8, cout=0.
REQ-031 a=255, b=1, cin=0 -> sum=0, cout=1; then a=0, b=0, cin=1 -> sum=1, cout=0.
REQ-032 a=170, b=85, cin=1 -> sum=0, cout=1 (carry ripple through all bits).
REQ-033 start held high throughout a=10, b=20 operation, with a/b changed to 99/99 mid-operation -> sum=30; next addition starts in cycle after DONE (IDLE), not during DONE.
REQ-034 rst asserted at cycle 6 of a=100, b=50 operation -> outputs 0 immediately, no done pulse; subsequent a=1, b=2 -> sum=3.
REQ-035 Random a, b, cin (>=1000 runs, WIDTH=8 and WIDTH=16) -> {cout,sum} equals a+b+cin; done one-cycle pulse at required latency.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl_pkg
//  Purpose  : Shared definitions for the bit-serial adder controller:
//             default operand width, 2-bit controller state encoding and a
//             helper that sizes the bit-index counter.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package serial_add_ctrl_pkg;

    // Default operand width; legal range is 2..32.
    localparam int c_DEFAULT_WIDTH = 8;

    // Controller state encoding.
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;  // waiting for start
    localparam state_t c_ST_HA1  = 2'd1;  // a[i] + b[i]      -> p, c1
    localparam state_t c_ST_HA2  = 2'd2;  // p + running carry -> sum[i], c2
    localparam state_t c_ST_DONE = 2'd3;  // result valid, one-cycle pulse

    // Bit-index counter width: ceil(log2(width)), never narrower than 1 bit.
    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ha_cell.sv
`default_nettype none
// ============================================================================
//  Module   : ha_cell
//  Purpose  : Combinational half adder, the single arithmetic cell shared by
//             both phases of every bit of the serial addition.
//  Ports    : x, y  - addend bits
//             s     - sum bit   (x XOR y)
//             c     - carry bit (x AND y)
//  Revision : 1.0  initial release
// ============================================================================
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Purpose  : Bit-serial adder computing {cout, sum} = a + b + cin, LSB
//             first, with one half-adder cell used twice per bit (HA1 then
//             HA2). One addition takes 2*WIDTH busy cycles plus a DONE cycle.
//  Ports    : clk   - clock, rising edge
//             rst   - asynchronous active-high reset
//             start - begin an addition (sampled in IDLE only)
//             a, b  - operands, latched on the accepting edge
//             cin   - carry-in, latched on the accepting edge
//             busy  - high in HA1/HA2
//             done  - one-cycle pulse when sum/cout are updated
//             sum   - registered result, low WIDTH bits
//             cout  - registered carry-out
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_IDX_W    = idx_width(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;      // result shift register, fills MSB-down
    logic [c_IDX_W-1:0] r_idx;
    logic               r_p;        // partial sum from HA1
    logic               r_c1;       // carry from HA1
    logic               r_carry;    // running carry into the current bit
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    // ------------------------------------------------------------------
    // Shared half-adder cell and its input steering
    // ------------------------------------------------------------------
    logic w_x;
    logic w_y;
    logic w_s;
    logic w_c;
    logic w_last;
    logic w_carry_next;

    // HA2 reuses the cell on the stored partial sum and the running carry;
    // every other state presents the current operand bits.
    always_comb begin
        w_x = r_a[r_idx];
        w_y = r_b[r_idx];
        if (r_state == c_ST_HA2) begin
            w_x = r_p;
            w_y = r_carry;
        end
    end

    ha_cell u_ha_cell (
        .x (w_x),
        .y (w_y),
        .s (w_s),
        .c (w_c)
    );

    // At most one of c1/c2 can be set for a bit, so OR forms the full-adder
    // carry out of the two half-adder passes.
    assign w_carry_next = r_c1 | w_c;
    assign w_last       = (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_HA1;
                end
            end
            c_ST_HA1: begin
                w_next_state = c_ST_HA2;
            end
            c_ST_HA2: begin
                w_next_state = w_last ? c_ST_DONE : c_ST_HA1;
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_idx   <= '0;
            r_p     <= 1'b0;
            r_c1    <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;   // carry-in seeds the running carry
                        r_idx   <= '0;
                        r_res   <= '0;
                    end
                end
                c_ST_HA1: begin
                    r_p  <= w_s;
                    r_c1 <= w_c;
                end
                c_ST_HA2: begin
                    // LSB-first: each new bit enters at the top, so after
                    // WIDTH shifts bit 0 sits at position 0.
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_carry_next;
                    if (w_last) begin
                        // Publish on the edge that enters DONE.
                        r_sum  <= {w_s, r_res[WIDTH-1:1]};
                        r_cout <= w_carry_next;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    // DONE: hold everything; start is ignored here.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state == c_ST_HA1) || (r_state == c_ST_HA2);
    assign done = (r_state == c_ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Purpose  : Self-checking bench for serial_add_ctrl at WIDTH=8 and 16.
//             A cycle-count model predicts busy/done/sum/cout every cycle;
//             directed cases pin known results, then randomized additions.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start8  = 1'b0;
    logic        cin8    = 1'b0;
    logic [7:0]  a8      = '0;
    logic [7:0]  b8      = '0;
    logic        busy8;
    logic        done8;
    logic        cout8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0;
    logic        cin16   = 1'b0;
    logic [15:0] a16     = '0;
    logic [15:0] b16     = '0;
    logic        busy16;
    logic        done16;
    logic        cout16;
    logic [15:0] sum16;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic int wid(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic bit start_of(input int d);
        return (d == 0) ? start8 : start16;
    endfunction

    function automatic longint unsigned total_of(input int d);
        if (d == 0) return 64'(a8) + 64'(b8) + 64'(cin8);
        return 64'(a16) + 64'(b16) + 64'(cin16);
    endfunction

    function automatic bit busy_of(input int d);
        return (d == 0) ? busy8 : busy16;
    endfunction

    function automatic bit done_of(input int d);
        return (d == 0) ? done8 : done16;
    endfunction

    function automatic longint unsigned res_of(input int d);
        if (d == 0) return {55'd0, cout8, sum8};
        return {47'd0, cout16, sum16};
    endfunction

    task automatic chk(input string name, input longint unsigned got,
                       input longint unsigned exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic drive(input int d, input bit s, input longint unsigned av,
                         input longint unsigned bv, input bit c);
        if (d == 0) begin
            start8 = s; a8 = 8'(av); b8 = 8'(bv); cin8 = c;
        end else begin
            start16 = s; a16 = 16'(av); b16 = 16'(bv); cin16 = c;
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: m_cnt counts edges since acceptance (0 = idle).
    // Busy for counts 1..2W, done at 2W+1, then idle again. The result is
    // the plain arithmetic sum of the accepted operands.
    // ------------------------------------------------------------------
    int unsigned     m_cnt  [2];
    longint unsigned m_total[2];
    longint unsigned m_res  [2];   // {cout, sum} currently expected

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_cnt[d]   <= 0;
                m_total[d] <= 0;
                m_res[d]   <= 0;
            end else if (m_cnt[d] == 0) begin
                if (start_of(d)) begin
                    m_total[d] <= total_of(d);
                    m_cnt[d]   <= 1;
                end
            end else if (m_cnt[d] < 2 * wid(d)) begin
                m_cnt[d] <= m_cnt[d] + 1;
            end else if (m_cnt[d] == 2 * wid(d)) begin
                m_cnt[d] <= m_cnt[d] + 1;
                m_res[d] <= m_total[d] & ((64'd1 << (wid(d) + 1)) - 1);
            end else begin
                m_cnt[d] <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy_w%0d", wid(d)), 64'(busy_of(d)),
                    64'(m_cnt[d] >= 1 && m_cnt[d] <= 2 * wid(d)));
                chk($sformatf("done_w%0d", wid(d)), 64'(done_of(d)),
                    64'(m_cnt[d] == 2 * wid(d) + 1));
                chk($sformatf("cout_sum_w%0d", wid(d)), res_of(d), m_res[d]);
            end
        end
    end

    // ------------------------------------------------------------------
    // One addition: request, release start after acceptance, then wait for
    // done within a bounded number of cycles. Returns at the done cycle.
    // ------------------------------------------------------------------
    task automatic run_op(input int d, input longint unsigned av,
                          input longint unsigned bv, input bit c,
                          input bit noise, output int lat, output int nbusy);
        @(posedge clk); #1;
        drive(d, 1'b1, av, bv, c);
        @(posedge clk); #1;
        drive(d, 1'b0, $urandom, $urandom, 1'($urandom));
        lat   = -1;
        nbusy = 0;
        for (int n = 1; n <= 2 * wid(d) + 8; n++) begin
            @(negedge clk);
            if (done_of(d)) begin
                lat = n;
                break;
            end
            if (busy_of(d)) nbusy++;
            if (noise) drive(d, 1'($urandom), $urandom, $urandom, 1'($urandom));
        end
        drive(d, 1'b0, $urandom, $urandom, 1'($urandom));
        chk($sformatf("latency_w%0d", wid(d)), 64'(lat), 64'(2 * wid(d) + 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int nbusy;
        int ndone;
        longint unsigned ra, rb;
        bit rc;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_sum8",  64'(sum8),  64'd0);
        chk("reset_cout8", 64'(cout8), 64'd0);
        chk("reset_busy8", 64'(busy8), 64'd0);
        chk("reset_done8", 64'(done8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3 + 5: 16 busy cycles, done in the 17th, sum 8
        run_op(0, 3, 5, 1'b0, 1'b0, lat, nbusy);
        chk("busy_cycles_3p5", 64'(nbusy), 64'd16);
        chk("sum_3p5",  64'(sum8),  64'd8);
        chk("cout_3p5", 64'(cout8), 64'd0);

        run_op(0, 255, 1, 1'b0, 1'b0, lat, nbusy);
        chk("sum_255p1",  64'(sum8),  64'd0);
        chk("cout_255p1", 64'(cout8), 64'd1);

        run_op(0, 0, 0, 1'b1, 1'b0, lat, nbusy);
        chk("sum_0p0c1",  64'(sum8),  64'd1);
        chk("cout_0p0c1", 64'(cout8), 64'd0);

        run_op(0, 170, 85, 1'b1, 1'b0, lat, nbusy);
        chk("sum_ripple",  64'(sum8),  64'd0);
        chk("cout_ripple", 64'(cout8), 64'd1);

        // start held high; operands changed mid-operation
        @(posedge clk); #1;
        drive(0, 1'b1, 10, 20, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        drive(0, 1'b1, 99, 99, 1'b0);
        ndone = 0;
        for (int n = 0; n < 40 && ndone == 0; n++) begin
            @(negedge clk);
            if (done8) ndone = 1;
        end
        chk("held_start_done_seen", 64'(ndone), 64'd1);
        chk("held_start_sum", 64'(sum8), 64'd30);
        @(negedge clk);
        chk("idle_after_done_busy", 64'(busy8), 64'd0);
        chk("idle_after_done_done", 64'(done8), 64'd0);
        @(negedge clk);
        chk("restart_after_idle", 64'(busy8), 64'd1);
        drive(0, 1'b0, 0, 0, 1'b0);
        ndone = 0;
        for (int n = 0; n < 40 && ndone == 0; n++) begin
            @(negedge clk);
            if (done8) ndone = 1;
        end
        chk("second_held_sum", 64'(sum8), 64'd198);

        // reset in cycle 6 of 100 + 50
        @(posedge clk); #1;
        drive(0, 1'b1, 100, 50, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_sum",  64'(sum8),  64'd0);
        chk("abort_cout", 64'(cout8), 64'd0);
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_done", 64'(done8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(0, 1, 2, 1'b0, 1'b0, lat, nbusy);
        chk("sum_after_abort", 64'(sum8), 64'd3);

        // 16-bit wrap and ripple
        run_op(1, 65535, 1, 1'b0, 1'b0, lat, nbusy);
        chk("busy_cycles_w16", 64'(nbusy), 64'd32);
        chk("wrap16_res", {47'd0, cout16, sum16}, 64'h10000);
        run_op(1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, lat, nbusy);
        chk("ripple16_res", {47'd0, cout16, sum16}, 64'h10000);

        // randomized additions, with start noise while busy on some runs
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = 64'($urandom) & ((64'd1 << wid(d)) - 1);
                rb = 64'($urandom) & ((64'd1 << wid(d)) - 1);
                rc = 1'($urandom);
                run_op(d, ra, rb, rc, ($urandom_range(0, 3) == 0), lat, nbusy);
                chk($sformatf("rand_res_w%0d", wid(d)), res_of(d), ra + rb + 64'(rc));
            end
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
